// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control path: FSM state encoding,
// timeout default, NOP encoding and the enable/bubble patterns driven by the hazard unit.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      HALT     = 2'b10
   } ctrl_state_t;

   localparam int          MEM_TIMEOUT_DEF = 255;
   localparam int          WAIT_CNT_W      = 8;
   localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;  // addi x0, x0, 0

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_write;
      logic id_ex_bubble;
      logic ex_mem_write;
      logic mem_wb_bubble;
   } ctrl_out_t;

   // Field order: pc_write, if_id_write, if_id_flush, id_ex_write,
   // id_ex_bubble, ex_mem_write, mem_wb_bubble
   localparam ctrl_out_t CTRL_NORMAL = ctrl_out_t'(7'b1101010);
   localparam ctrl_out_t CTRL_STALL  = ctrl_out_t'(7'b0001110);
   localparam ctrl_out_t CTRL_FLUSH  = ctrl_out_t'(7'b1111110);
   localparam ctrl_out_t CTRL_HOLD   = ctrl_out_t'(7'b0000001);
   localparam ctrl_out_t CTRL_HALT   = ctrl_out_t'(7'b0000000);
   localparam ctrl_out_t CTRL_RESET  = ctrl_out_t'(7'b0010101);

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load still in EX (x0 never creates a dependency).
module load_use_detect (
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic       uses_rs2,
   input  logic       mem_read,
   input  logic [4:0] rd,
   output logic       hazard
);

   logic rs1_match;
   logic rs2_match;

   assign rs1_match = (rd == rs1);
   assign rs2_match = uses_rs2 && (rd == rs2);
   assign hazard    = mem_read && (rd != 5'd0) && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline stall/flush/freeze controller with data-memory watchdog.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_control_unit
   import pipeline_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int CNT_W = 32
`endif
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [4:0] if_id_rs1,
   input  logic [4:0] if_id_rs2,
   input  logic       if_id_uses_rs2,
   input  logic       id_ex_MemRead,
   input  logic [4:0] id_ex_rd,
   input  logic       ex_branch_taken,
   input  logic       dmem_req,
   input  logic       dmem_ready,
   output logic       PCWrite,
   output logic       IF_ID_Write,
   output logic       IF_ID_Flush,
   output logic       ID_EX_Write,
   output logic       ID_EX_Bubble,
   output logic       EX_MEM_Write,
   output logic       MEM_WB_Bubble,
   output logic       halted
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
`endif
);

   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_C = WAIT_CNT_W'(MEM_TIMEOUT);

   ctrl_state_t           state;
   ctrl_state_t           state_next;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  lu_hazard;
   logic                  mem_hold;
   ctrl_out_t             ctrl;
   ctrl_out_t             ctrl_out;

   load_use_detect u_load_use_detect (
      .rs1      (if_id_rs1),
      .rs2      (if_id_rs2),
      .uses_rs2 (if_id_uses_rs2),
      .mem_read (id_ex_MemRead),
      .rd       (id_ex_rd),
      .hazard   (lu_hazard)
   );

   // In MEM_WAIT a fresh dmem_req is meaningless; only dmem_ready matters.
   assign mem_hold = ((state == MEM_WAIT) && !dmem_ready) ||
                     ((state == RUN) && dmem_req && !dmem_ready);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      ctrl       = CTRL_NORMAL;

      case (state)
         RUN: begin
            if (dmem_req && !dmem_ready) state_next = MEM_WAIT;
         end
         MEM_WAIT: begin
            if (dmem_ready)                 state_next = RUN;
            else if (wait_cnt == TIMEOUT_C) state_next = HALT;
         end
         HALT:    state_next = HALT;
         default: state_next = RUN;
      endcase

      // A branch held by a memory freeze stays in EX, so its flush lands in
      // the first unfrozen cycle without any extra bookkeeping.
      if (state == HALT)         ctrl = CTRL_HALT;
      else if (mem_hold)         ctrl = CTRL_HOLD;
      else if (ex_branch_taken)  ctrl = CTRL_FLUSH;
      else if (lu_hazard)        ctrl = CTRL_STALL;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= '0;
      end else if (state != MEM_WAIT) begin
         wait_cnt <= '0;
      end else if (wait_cnt != TIMEOUT_C) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign ctrl_out      = reset_n ? ctrl : CTRL_RESET;
   assign PCWrite       = ctrl_out.pc_write;
   assign IF_ID_Write   = ctrl_out.if_id_write;
   assign IF_ID_Flush   = ctrl_out.if_id_flush;
   assign ID_EX_Write   = ctrl_out.id_ex_write;
   assign ID_EX_Bubble  = ctrl_out.id_ex_bubble;
   assign EX_MEM_Write  = ctrl_out.ex_mem_write;
   assign MEM_WB_Bubble = ctrl_out.mem_wb_bubble;
   assign halted        = reset_n && (state == HALT);

`ifdef HAZARD_PERF_CNT_EN
   logic stall_event;
   logic flush_event;

   // Count only stalls that are actually applied: a load-use masked by a
   // taken branch is squashed, not stalled.
   assign stall_event = (state != HALT) && (mem_hold || (lu_hazard && !ex_branch_taken));
   assign flush_event = (state != HALT) && ex_branch_taken && !mem_hold;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall_event && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
         if (flush_event && (flush_count != '1))  flush_count  <= flush_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: vector table, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_hazard_control_unit;

   localparam int TB_TIMEOUT = 4;
   localparam int TB_CNT_W   = 32;

   // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble}
   localparam logic [6:0] E_NORM  = 7'b1101010;
   localparam logic [6:0] E_STALL = 7'b0001110;
   localparam logic [6:0] E_FLUSH = 7'b1111110;
   localparam logic [6:0] E_HOLD  = 7'b0000001;
   localparam logic [6:0] E_HALT  = 7'b0000000;
   localparam logic [6:0] E_RST   = 7'b0010101;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic       uses = 1'b0, mr = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;
   logic       PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble;
   logic       EX_MEM_Write, MEM_WB_Bubble, halted;
   logic [6:0] got_ctrl;
`ifdef HAZARD_PERF_CNT_EN
   logic [TB_CNT_W-1:0] stall_cycles, flush_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: outstanding-access flag, wait cycles elapsed, halted flag.
   bit m_wait;
   int m_waited;
   bit m_halt;
   int m_stall;
   int m_flush;

   always #5 clk = ~clk;

   hazard_control_unit #(
      .MEM_TIMEOUT (TB_TIMEOUT)
`ifdef HAZARD_PERF_CNT_EN
      , .CNT_W     (TB_CNT_W)
`endif
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .if_id_rs1       (rs1),
      .if_id_rs2       (rs2),
      .if_id_uses_rs2  (uses),
      .id_ex_MemRead   (mr),
      .id_ex_rd        (rd),
      .ex_branch_taken (br),
      .dmem_req        (req),
      .dmem_ready      (rdy),
      .PCWrite         (PCWrite),
      .IF_ID_Write     (IF_ID_Write),
      .IF_ID_Flush     (IF_ID_Flush),
      .ID_EX_Write     (ID_EX_Write),
      .ID_EX_Bubble    (ID_EX_Bubble),
      .EX_MEM_Write    (EX_MEM_Write),
      .MEM_WB_Bubble   (MEM_WB_Bubble),
      .halted          (halted)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cycles  (stall_cycles),
      .flush_count     (flush_count)
`endif
   );

   assign got_ctrl = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
                      ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble};

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       uses;
      logic       mr;
      logic [4:0] rd;
      logic       br;
      logic [6:0] exp;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic bit model_lu();
      return mr && (rd != 5'd0) && ((rd == rs1) || (uses && (rd == rs2)));
   endfunction

   function automatic bit model_mh();
      return m_wait ? !rdy : (req && !rdy);
   endfunction

   function automatic logic [6:0] model_ctrl();
      if (m_halt)          return E_HALT;
      if (model_mh())      return E_HOLD;
      if (br)              return E_FLUSH;
      if (model_lu())      return E_STALL;
      return E_NORM;
   endfunction

   task automatic model_advance();
      bit lu, mh;
      lu = model_lu();
      mh = model_mh();
      if (m_halt) return;
      if (mh || (lu && !br)) m_stall++;
      if (br && !mh)         m_flush++;
      if (m_wait) begin
         if (rdy) m_wait = 0;
         else begin
            m_waited++;
            if (m_waited > TB_TIMEOUT) begin
               m_halt = 1;
               m_wait = 0;
            end
         end
      end else if (req && !rdy) begin
         m_wait   = 1;
         m_waited = 0;
      end
   endtask

   task automatic step(input logic [4:0] a1, input logic [4:0] a2, input logic u,
                       input logic m, input logic [4:0] d, input logic b,
                       input logic q, input logic r, input string name);
      @(posedge clk);
      #1;
      rs1 = a1; rs2 = a2; uses = u; mr = m; rd = d; br = b; req = q; rdy = r;
      @(negedge clk);
      check({name, "_ctrl"}, 32'(got_ctrl), 32'(model_ctrl()));
      check({name, "_halted"}, 32'(halted), 32'(m_halt));
`ifdef HAZARD_PERF_CNT_EN
      check({name, "_stall_cnt"}, stall_cycles, m_stall);
      check({name, "_flush_cnt"}, flush_count, m_flush);
`endif
      model_advance();
   endtask

   task automatic idle(input string name);
      step(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, name);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      rs1 = '0; rs2 = '0; uses = 0; mr = 0; rd = '0; br = 0; req = 0; rdy = 0;
      #1;
      check("reset_ctrl", 32'(got_ctrl), 32'(E_RST));
      check("reset_halted", 32'(halted), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
      check("reset_stall_cnt", stall_cycles, 32'd0);
      check("reset_flush_cnt", flush_count, 32'd0);
`endif
      m_wait = 0; m_waited = 0; m_halt = 0; m_stall = 0; m_flush = 0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      tbl[0] = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd1, 1'b0, E_NORM};   // not a load
      tbl[1] = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, E_STALL};  // rs1 match
      tbl[2] = '{5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, E_STALL};  // rs2 match
      tbl[3] = '{5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, E_NORM};   // rs2 unused
      tbl[4] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, E_NORM};   // load to x0
      tbl[5] = '{5'd4, 5'd6, 1'b1, 1'b1, 5'd9, 1'b0, E_NORM};   // no match
      tbl[6] = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, E_FLUSH};  // branch only
      tbl[7] = '{5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, E_FLUSH};  // branch beats LU

      do_reset();

      foreach (tbl[i]) begin
         step(tbl[i].rs1, tbl[i].rs2, tbl[i].uses, tbl[i].mr, tbl[i].rd, tbl[i].br,
              1'b0, 1'b0, "tbl");
         check($sformatf("tbl%0d", i), 32'(got_ctrl), 32'(tbl[i].exp));
      end

      // Load-use stall lasts one cycle
      step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, "lu");
      check("lu_stall", 32'(got_ctrl), 32'(E_STALL));
      idle("lu_after");
      check("lu_release", 32'(got_ctrl), 32'(E_NORM));

      // Three-cycle memory hold, released in the ready cycle
      step(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, "mh_req");
      check("mh_req_hold", 32'(got_ctrl), 32'(E_HOLD));
      idle("mh_w1");
      check("mh_w1_hold", 32'(got_ctrl), 32'(E_HOLD));
      idle("mh_w2");
      check("mh_w2_hold", 32'(got_ctrl), 32'(E_HOLD));
      step(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, "mh_rdy");
      check("mh_rdy_release", 32'(got_ctrl), 32'(E_NORM));
      idle("mh_run");
      check("mh_back_in_run", 32'(got_ctrl), 32'(E_NORM));

      // Zero-wait access does not hold
      step(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, "zw");
      check("zero_wait", 32'(got_ctrl), 32'(E_NORM));

      // Branch during hold: flush deferred until the hold ends
      step(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, "brmh_req");
      check("brmh_held", 32'(got_ctrl), 32'(E_HOLD));
      step(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, "brmh_rdy");
      check("brmh_flush", 32'(got_ctrl), 32'(E_FLUSH));

      // Watchdog: request cycle, then TB_TIMEOUT+1 wait cycles, then HALT
      step(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, "to_req");
      cyc = 0;
      while (!halted && cyc < 20) begin
         idle("to_wait");
         cyc++;
      end
      check("halt_latency", 32'(cyc), 32'(TB_TIMEOUT + 2));
      check("halt_ctrl", 32'(got_ctrl), 32'(E_HALT));
      for (int k = 0; k < 3; k++) begin
         step(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, "halt_stay");
         check("halt_sticky", 32'(halted), 32'd1);
      end
      do_reset();
      idle("post_halt");
      check("post_halt_run", 32'(got_ctrl), 32'(E_NORM));
      check("post_halt_flag", 32'(halted), 32'd0);

      // 2 load-use stalls + 3 hold cycles + 1 flush
      do_reset();
      step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, "pc_lu1");
      idle("pc_i1");
      step(5'd0, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, "pc_lu2");
      step(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, "pc_req");
      idle("pc_h1");
      idle("pc_h2");
      step(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, "pc_rdy");
      step(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, "pc_br");
      idle("pc_end");
`ifdef HAZARD_PERF_CNT_EN
      check("perf_stall_total", stall_cycles, 32'd5);
      check("perf_flush_total", flush_count, 32'd1);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         if (i % 250 == 0) do_reset();
         step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 2) == 0), "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
